// File: rtl/cp0_pkg.sv
// cp0_pkg: register numbers, exception codes and EXL state constants shared by the CP0 files.
package cp0_pkg;
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
    localparam logic [0:0] ST_NORMAL  = 1'b0;
    localparam logic [0:0] ST_HANDLER = 1'b1;
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare pair and sticky timer-pending flag, built only with CP0_TIMER_EN.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        iWE,
    input  logic [4:0]  iA2,
    input  logic [31:0] iDin,
    output logic [31:0] oCount,
    output logic [31:0] oCompare,
    output logic        oPend
);
    logic [31:0] r_count, r_compare;
    logic        r_pend;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_pend    <= 1'b0;
        end else begin
            r_count <= (iWE && iA2 == CP0_COUNT) ? iDin : r_count + 32'd1;
            // a Compare write acknowledges the timer, even on a matching cycle
            if (iWE && iA2 == CP0_COMPARE) begin
                r_compare <= iDin;
                r_pend    <= 1'b0;
            end else if (r_count == r_compare) begin
                r_pend <= 1'b1;
            end
        end
    end
    assign oCount   = r_count;
    assign oCompare = r_compare;
    assign oPend    = r_pend;
endmodule

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: CP0 SR/Cause/EPC/PRId and the M-stage interrupt/exception decision.
// Define CP0_TIMER_EN to add Count(9)/Compare(11) with the timer on hardware interrupt 5.
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h0000_0707
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  iA1,
    input  logic [4:0]  iA2,
    input  logic [31:0] iDin,
    input  logic        iWE,
    input  logic [31:0] iPC,
    input  logic        iBD,
    input  logic [4:0]  iExcCode,
    input  logic [5:0]  iHWInt,
    input  logic        iEXLClr,
    output logic [31:0] oDout,
    output logic [31:0] oEPC,
    output logic        oINT
);
    logic [5:0]  r_im, r_ip;
    logic        r_exl, r_ie, r_bd;
    logic [4:0]  r_code;
    logic [31:0] r_epc;
    logic [5:0]  w_hw;
    logic        w_irq, w_exc, w_we, w_wr_sr;
    logic [31:0] w_pc;
`ifdef CP0_TIMER_EN
    logic [31:0] w_count, w_compare;
    logic        w_pend;
    cp0_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .iWE      (w_we),
        .iA2      (iA2),
        .iDin     (iDin),
        .oCount   (w_count),
        .oCompare (w_compare),
        .oPend    (w_pend)
    );
    assign w_hw = {iHWInt[5] | w_pend, iHWInt[4:0]};
`else
    assign w_hw = iHWInt;
`endif
    assign w_irq   = |(w_hw & r_im) & r_ie & ~r_exl;
    assign w_exc   = (iExcCode != EXC_INT) & ~r_exl;
    assign oINT    = w_irq | w_exc;
    // exception entry owns this edge, so any mtc0 in the same cycle is dropped
    assign w_we    = iWE & ~oINT;
    assign w_wr_sr = w_we && iA2 == CP0_SR;
    assign w_pc    = iPC & 32'hFFFF_FFFC;
    assign oEPC    = r_epc;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_im   <= 6'h3F;
            r_exl  <= ST_NORMAL;
            r_ie   <= 1'b1;
            r_bd   <= 1'b0;
            r_ip   <= 6'h0;
            r_code <= EXC_INT;
            r_epc  <= 32'h0;
        end else begin
            r_ip <= w_hw;
            if (oINT) begin
                r_exl  <= ST_HANDLER;
                r_bd   <= iBD;
                r_code <= w_irq ? EXC_INT : iExcCode;
                r_epc  <= iBD ? w_pc - 32'd4 : w_pc;
            end else begin
                if (w_wr_sr) begin
                    r_im <= iDin[15:10];
                    r_ie <= iDin[0];
                end
                r_exl <= iEXLClr ? ST_NORMAL : w_wr_sr ? iDin[1] : r_exl;
                if (w_we && iA2 == CP0_EPC) r_epc <= iDin;
            end
        end
    end
    always_comb begin
        oDout = 32'h0;
        case (iA1)
            CP0_SR:      oDout = {16'h0, r_im, 8'h0, r_exl, r_ie};
            CP0_CAUSE:   oDout = {r_bd, 15'h0, r_ip, 3'h0, r_code, 2'h0};
            CP0_EPC:     oDout = r_epc;
            CP0_PRID:    oDout = PRID_VALUE;
`ifdef CP0_TIMER_EN
            CP0_COUNT:   oDout = w_count;
            CP0_COMPARE: oDout = w_compare;
`endif
            default:     oDout = 32'h0;
        endcase
    end
endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- System coprocessor 0 for the P7 pipeline.
- Holds SR, Cause, EPC and PRId, and decides whether to take an interrupt or exception this cycle.
- Drives oINT and oEPC into the next-PC selector: oINT redirects fetch to the handler at 0x4180, and oEPC is the target of eret.
- Sits at the M stage; the victim PC, branch-delay flag and exception code come from the pipeline registers.

Parameters:
- PRID_VALUE, 32'h0000_0707, read-only contents of PRId (reg 15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all CP0 state immediately.
- iA1  input  5  read register number (mfc0).
- iA2  input  5  write register number (mtc0).
- iDin  input  32  mtc0 write data.
- iWE  input  1  mtc0 write enable.
- iPC  input  32  PC of the M-stage instruction (exception victim).
- iBD  input  1  M-stage instruction is in a branch delay slot.
- iExcCode  input  5  pending internal exception code; 0 means none.
- iHWInt  input  6  external interrupt lines, level-sensitive.
- iEXLClr  input  1  eret in M stage.
- oDout  output  32  read data for iA1.
- oEPC  output  32  current EPC.
- oINT  output  1  take exception/interrupt this cycle.

Behaviour:
- Reset values:
  - SR.IM = 6'h3F, SR.EXL = 0, SR.IE = 1.
  - Cause = 0 and EPC = 0.
  - oINT = 0 and oDout = 0 for any read address other than 12 (SR), which returns SR's reset value, or 15 (PRId), which returns PRID_VALUE.
- Register layout:
  - SR(12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - EPC(14): full 32 bits.
  - PRId(15): PRID_VALUE.
- Read path:
  - Combinational mux on iA1; unmapped numbers read 0.
  - No same-cycle write bypass: a read returns the pre-edge value.
- Cause.IP:
  - Loaded from iHWInt every cycle, regardless of any other event.
  - Not writable by mtc0; writes to Cause are ignored entirely.
- Interrupt and exception decision (combinational, same cycle):
  - irq = |(iHWInt & SR.IM) & SR.IE & ~SR.EXL.
  - exc = (iExcCode != 0) & ~SR.EXL.
  - oINT = irq | exc.
- State machine on SR.EXL:
  - NORMAL (EXL=0): on oINT, go to HANDLER at the next edge and perform the exception entry below.
  - HANDLER (EXL=1): oINT is forced 0; on iEXLClr, go to NORMAL (EXL <= 0).
- Exception entry (on the edge where oINT=1):
  - EXL <= 1.
  - Cause.BD <= iBD.
  - Cause.ExcCode <= irq ? 5'd0 : iExcCode (interrupt has priority).
  - EPC <= iBD ? {iPC[31:2],2'b00} - 4 : {iPC[31:2],2'b00}.
- mtc0:
  - Writes to SR (IM, EXL, IE only) and EPC take effect at the edge.
  - Writes to Cause, PRId and unmapped numbers are discarded.
- Simultaneous events:
  - oINT=1 with iWE=1: the exception entry wins and the write is dropped.
  - oINT=1 with iEXLClr=1: the exception entry wins, so EXL ends at 1.
  - iEXLClr with iWE to SR: iEXLClr wins for EXL; the IM and IE bits still take the written value.
- Reset asserted mid-handler: EXL returns to 0 at once and any pending entry is abandoned.
- oEPC is a direct register output, one cycle after entry.

Optional Feature:
- Macro: CP0_TIMER_EN.
- When defined:
  - Count (reg 9) increments every cycle and wraps at 2^32.
  - Compare (reg 11) is writable via mtc0; writing Compare clears the timer pending flag.
  - Count==Compare sets the timer pending flag, which stays set until cleared.
  - The pending flag is ORed into iHWInt[5] for both Cause.IP[15] and the irq term.
  - Count is also writable; a write to Count takes priority over the increment.
  - Both Count and Compare reset to 0, with the pending flag clear.
- When undefined:
  - Regs 9 and 11 read 0 and ignore writes.
  - iHWInt[5] is used unmodified.

Decomposition:
- Shared package `cp0_pkg`:
  - Register numbers: CP0_SR = 12, CP0_CAUSE = 13, CP0_EPC = 14, CP0_PRID = 15, CP0_COUNT = 9, CP0_COMPARE = 11.
  - ExcCode constants: EXC_INT = 0, EXC_ADEL = 4, EXC_ADES = 5, EXC_RI = 10, EXC_OV = 12.
  - Handler address: 32'h0000_4180.
- One natural sub-module, `cp0_timer`: owns Count, Compare and the pending flag, and exists only under CP0_TIMER_EN.

Test Plan:
- Reset, then read 12/15 -> Dout = 32'h0000_FC01 and PRID_VALUE; oINT = 0.
- iHWInt = 6'b000100 in NORMAL, iPC = 32'h3010 -> oINT = 1 that cycle; next cycle EXL = 1, Cause.ExcCode = 0, IP[12] = 1, oEPC = 32'h3010.
- iExcCode = 12, iBD = 1, iPC = 32'h3020 -> oINT = 1; then EPC = 32'h301C, BD = 1, ExcCode = 12; a second iExcCode while EXL = 1 -> oINT = 0.
- iEXLClr in HANDLER -> EXL = 0 next cycle; an interrupt held high during the eret cycle -> oINT = 0 that cycle, oINT = 1 the following cycle.
- mtc0 SR = 32'h0 then iHWInt = 6'h3F -> oINT = 0; mtc0 with a same-cycle iExcCode = 4 -> write dropped, entry taken.
- CP0_TIMER_EN: write Compare = 10 with Count reset -> pending flag and Cause.IP[15] set when Count reaches 10, oINT asserts; write Compare -> pending flag cleared.
